// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants, op encodings and mul/div state type
package mips_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } md_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit owning HI/LO
module mul_div_unit
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   md_state_t       state, state_next;
   logic            accept;
   logic [CW-1:0]   count;
   logic            is_div_q;
   logic            neg_q;      // negate product (mul) or quotient (div)
   logic            neg_r;      // negate remainder (dividend was negative)
   logic [W-1:0]    opnd;       // multiplicand magnitude or divisor magnitude
   logic [2*W-1:0]  acc;        // product accumulator, or {remainder, quotient}
   logic [2*W-1:0]  acc_next;

   logic            is_div_in, is_signed_in, a_neg, b_neg, b_zero;
   logic            neg_q_in, neg_r_in;
   logic [W-1:0]    a_mag_in, b_mag_in;

   logic [W:0]      add_sum;
   logic [W:0]      sub_diff;
   logic [2*W-1:0]  prod_fix;
   logic [W-1:0]    quot_fix, rem_fix;

   // Operand pre-processing at start: magnitudes and sign flags.
   // A zero divisor keeps the raw dividend and no sign flags, so the restoring
   // loop naturally yields quotient all-ones and remainder equal to A.
   always_comb begin
      is_div_in    = (op == MD_DIV)  || (op == MD_DIVU);
      is_signed_in = (op == MD_MULT) || (op == MD_DIV);
      a_neg        = is_signed_in & A[W-1];
      b_neg        = is_signed_in & B[W-1];
      b_zero       = is_div_in && (B == '0);
      a_mag_in     = (a_neg && !b_zero) ? -A : A;
      b_mag_in     = b_neg ? -B : B;
      neg_q_in     = (a_neg ^ b_neg) & ~b_zero;
      neg_r_in     = a_neg & ~b_zero;
   end

   // One iteration: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
      sub_diff = acc[2*W-1:W-1] - {1'b0, opnd};
      acc_next = acc;
      if (is_div_q) begin
         if (!sub_diff[W])
            acc_next = {sub_diff[W-1:0], acc[W-2:0], 1'b1};
         else
            acc_next = {acc[2*W-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_next = {add_sum, acc[W-1:1]};
         else
            acc_next = {1'b0, acc[2*W-1:1]};
      end
   end

   // Sign post-correction of the finished result.
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quot_fix = neg_q ? -acc[W-1:0] : acc[W-1:0];
      rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; FIX already counts as idle for accepting a new start.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            if (&count)
               state_next = FIX;
         end
         FIX: begin
            state_next = IDLE;
            if (start) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath, HI/LO and registered status outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         count    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
      end else begin
         busy <= (state_next != IDLE);
         done <= (state == FIX);
         if (state == IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
         if (state == FIX) begin
            if (is_div_q) begin
               hi <= rem_fix;
               lo <= quot_fix;
            end else begin
               {hi, lo} <= prod_fix;
            end
         end
         if (accept) begin
            count    <= '0;
            is_div_q <= is_div_in;
            neg_q    <= neg_q_in;
            neg_r    <= neg_r_in;
            opnd     <= is_div_in ? b_mag_in : a_mag_in;
            acc      <= is_div_in ? {{W{1'b0}}, a_mag_in} : {{W{1'b0}}, b_mag_in};
         end else if (state == CALC) begin
            count <= count + 1'b1;
            acc   <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit
module tb_mul_div_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [63:0] sb_q[$];
   logic [63:0] mon_exp;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .A(A), .B(B),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // Reference model: {HI, LO} from native arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic signed [31:0] sa, sbv, q, m;
      logic [63:0]        r;
      sa = a;
      sbv = b;
      case (o)
         2'b00: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r  = sp;
         end
         2'b01: r = {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 32'h0)
               r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = {32'h0, 32'h8000_0000};
            else begin
               q = sa / sbv;
               m = sa % sbv;
               r = {m, q};
            end
         end
         default: begin
            if (b == 32'h0)
               r = {a, 32'hFFFF_FFFF};
            else
               r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   // Scoreboard: every done pulse pops one expected {HI, LO}.
   always @(negedge clk) begin
      if (done) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected_done: got hi=%h lo=%h, expected no result", hi, lo);
         end else begin
            mon_exp = sb_q.pop_front();
            if ({hi, lo} !== mon_exp)
               $display("FAIL sb_result: got hi=%h lo=%h, expected hi=%h lo=%h",
                        hi, lo, mon_exp[63:32], mon_exp[31:0]);
            else
               n_pass++;
         end
      end
   end

   // Drive a one-cycle start; returns just after the start edge E0.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_v);
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      sb_q.push_back(exp_v);
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom_range(3));
      A = $urandom;
      B = $urandom;
   endtask

   // Count negedges after E0 until done (bounded); -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks += 4;
      if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi); else n_pass++;
      if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo); else n_pass++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_multu_timing();
      logic [31:0] prev_hi, prev_lo;
      int busy_bad, hold_bad, lat;
      prev_hi = hi;
      prev_lo = lo;
      busy_bad = 0;
      hold_bad = 0;
      lat = -1;
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
      n_checks++;
      if (busy !== 1'b1) $display("FAIL multu_busy_e0: got %b expected 1", busy); else n_pass++;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
         if (hi !== prev_hi || lo !== prev_lo) hold_bad++;
      end
      n_checks += 4;
      if (lat != 33) $display("FAIL multu_latency: got %0d expected 33", lat); else n_pass++;
      if (busy_bad != 0) $display("FAIL multu_busy_calc: got %0d low cycles expected 0", busy_bad); else n_pass++;
      if (hold_bad != 0) $display("FAIL multu_hilo_hold: got %0d changed cycles expected 0", hold_bad); else n_pass++;
      if (busy !== 1'b0) $display("FAIL multu_busy_e33: got %b expected 0", busy); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL multu_done_pulse: got %b expected 0 one cycle later", done); else n_pass++;
   endtask

   task automatic test_directed_ops();
      logic [1:0]  ops  [6] = '{MD_MULT, MD_DIV, MD_DIVU, MD_DIVU, MD_DIV, MD_DIV};
      logic [31:0] as   [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
      logic [31:0] bs   [6] = '{32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [63:0] exps [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFEB}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                {32'd2, 32'd14}, {32'd7, 32'hFFFF_FFFF},
                                {32'h0, 32'h8000_0000}, {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], as[i], bs[i], exps[i]);
         wait_done(lat);
         n_checks++;
         if (lat != 33) $display("FAIL directed_latency[%0d]: got %0d expected 33", i, lat); else n_pass++;
      end
   endtask

   task automatic test_random_ops();
      logic [1:0]  o;
      logic [31:0] a, b;
      int lat;
      for (int i = 0; i < 12; i++) begin
         o = 2'(i % 4);
         a = $urandom;
         case (i / 4)
            0:       b = $urandom;
            1:       b = 32'($urandom_range(15));
            default: b = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF - 32'($urandom_range(3));
         endcase
         issue(o, a, b, model(o, a, b));
         wait_done(lat);
         n_checks++;
         if (lat != 33) $display("FAIL random_latency[%0d]: got %0d expected 33", i, lat); else n_pass++;
      end
   endtask

   task automatic test_start_while_busy();
      int lat;
      lat = -1;
      issue(MD_DIVU, 32'd1000, 32'd10, {32'd0, 32'd100});
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 4) begin
            start = 1'b1; op = MD_MULT; A = 32'd5; B = 32'd6;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      n_checks++;
      if (lat != 33) $display("FAIL busy_start_latency: got %0d expected 33", lat); else n_pass++;
      repeat (40) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL busy_start_ignored: got busy=%b expected 0", busy); else n_pass++;
   endtask

   task automatic test_mt_writes();
      int lat;
      int hi_bad;
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk);
      lo_we = 1'b0;
      n_checks++;
      if (lo !== 32'h0000_1234) $display("FAIL mtlo_idle: got %h expected 00001234", lo); else n_pass++;
      hi_we = 1'b1; wdata = 32'hCAFE_0000;
      @(negedge clk);
      hi_we = 1'b0;
      n_checks += 2;
      if (hi !== 32'hCAFE_0000) $display("FAIL mthi_idle: got %h expected cafe0000", hi); else n_pass++;
      if (lo !== 32'h0000_1234) $display("FAIL mthi_keeps_lo: got %h expected 00001234", lo); else n_pass++;

      // MTHI arriving while busy is dropped
      hi_bad = 0;
      lat = -1;
      issue(MD_MULTU, 32'd3, 32'd5, {32'd0, 32'd15});
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 9) begin
            hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
         end else begin
            hi_we = 1'b0;
         end
         if (k == 10 && hi !== 32'hCAFE_0000) hi_bad = 1;
         if (done) begin
            lat = k;
            break;
         end
      end
      hi_we = 1'b0;
      n_checks += 2;
      if (hi_bad != 0) $display("FAIL mthi_busy_dropped: got hi changed expected cafe0000 held"); else n_pass++;
      if (lat != 33) $display("FAIL mthi_busy_latency: got %0d expected 33", lat); else n_pass++;

      // MTLO together with start: write lands, result later overwrites it
      @(negedge clk);
      start = 1'b1; op = MD_DIVU; A = 32'd20; B = 32'd6;
      lo_we = 1'b1; wdata = 32'h5555_5555;
      sb_q.push_back({32'd2, 32'd3});
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      n_checks += 2;
      if (lo !== 32'h5555_5555) $display("FAIL mtlo_with_start: got %h expected 55555555", lo); else n_pass++;
      if (busy !== 1'b1) $display("FAIL mtlo_with_start_busy: got %b expected 1", busy); else n_pass++;
      wait_done(lat);
      n_checks++;
      if (lat != 33) $display("FAIL mtlo_with_start_latency: got %0d expected 33", lat); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int lat;
      issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      repeat (14) @(negedge clk);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      sb_q.delete();
      n_checks += 4;
      if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else n_pass++;
      if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else n_pass++;
      if (hi !== 32'h0) $display("FAIL midreset_hi: got %h expected 0", hi); else n_pass++;
      if (lo !== 32'h0) $display("FAIL midreset_lo: got %h expected 0", lo); else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      issue(MD_DIVU, 32'd9, 32'd3, {32'd0, 32'd3});
      wait_done(lat);
      n_checks++;
      if (lat != 33) $display("FAIL midreset_fresh_latency: got %0d expected 33", lat); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_multu_timing();
      test_directed_ops();
      test_random_ops();
      test_start_while_busy();
      test_mt_writes();
      test_reset_mid_op();
      repeat (2) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
